// File: rtl/pwm_rgb_led_axil_slave.sv
// ============================================================================
//  Module      : pwm_rgb_led_axil_slave
//  Description : AXI4-Lite slave with four 32-bit registers (CTRL, DUTY_R,
//                DUTY_G, DUTY_B) driving three registered PWM LED outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_rgb_led_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int PRESCALE           = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // write response channel
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // PWM outputs
    output logic                            led_r,
    output logic                            led_g,
    output logic                            led_b
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_nbytes  = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_idx_lsb = 2;   // word-aligned register select
    localparam int c_nregs   = 4;
    localparam int c_pre_w   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(PRESCALE - 1);

    // ------------------------------------------------------------------------
    // Register file and bus-side state
    // ------------------------------------------------------------------------
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [c_nregs];

    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic [c_pre_w-1:0]            r_pre;
    logic [7:0]                    r_cnt;
    logic [2:0]                    r_led;

    logic                          w_wr_accept;
    logic                          w_wr_fire;
    logic [1:0]                    w_wr_idx;
    logic                          w_rd_accept;
    logic                          w_rd_fire;
    logic [1:0]                    w_rd_idx;
    logic                          w_en;
    logic [2:0]                    w_led_next;

    // A write is taken only when both halves are present and the previous
    // response has been consumed; the ready pulse itself blocks re-entry.
    assign w_wr_accept = S_AXI_AWVALID & S_AXI_WVALID & ~r_awready & ~r_bvalid;
    assign w_wr_fire   = r_awready & S_AXI_AWVALID & r_wready & S_AXI_WVALID;
    assign w_wr_idx    = S_AXI_AWADDR[c_idx_lsb +: 2];

    // A read is taken only when no read data is still waiting for RREADY.
    assign w_rd_accept = S_AXI_ARVALID & ~r_arready & ~r_rvalid;
    assign w_rd_fire   = r_arready & S_AXI_ARVALID;
    assign w_rd_idx    = S_AXI_ARADDR[c_idx_lsb +: 2];

    assign w_en        = r_regs[0][0];

    // Protection bits and byte-offset address bits carry no meaning here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------------------
    // Write channel: one-cycle AWREADY/WREADY pulse, then hold BVALID
    // ------------------------------------------------------------------------
    // Ready pulse generation for the write address and data channels
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
        end else begin
            r_awready <= w_wr_accept;
            r_wready  <= w_wr_accept;
        end
    end

    // Write response: raised on the handshake edge, dropped when accepted
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_bvalid <= 1'b0;
        end else if (w_wr_fire) begin
            r_bvalid <= 1'b1;
        end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Register file update with per-byte strobes on the handshake edge
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < c_nregs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_fire) begin
            for (int k = 0; k < c_nbytes; k++) begin
                if (S_AXI_WSTRB[k]) begin
                    r_regs[w_wr_idx][8*k +: 8] <= S_AXI_WDATA[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read channel: one-cycle ARREADY pulse, data captured on that edge
    // ------------------------------------------------------------------------
    // Read address ready pulse
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
        end else begin
            r_arready <= w_rd_accept;
        end
    end

    // Read data capture; the register value sampled here predates any write
    // committed on the same edge
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_regs[w_rd_idx];
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // PWM timebase: prescaler then 8-bit step counter, parked at 0 when off
    // ------------------------------------------------------------------------
    // Prescaler and step counter advance only while enabled
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (!w_en) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (r_pre == c_pre_max) begin
            r_pre <= '0;
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Per-channel comparators; only the low byte of each duty register counts
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_led
            assign w_led_next[g] = w_en & (r_cnt < r_regs[g+1][7:0]);
        end
    endgenerate

    // Registered LED outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_rvalid;
    assign led_r         = r_led[0];
    assign led_g         = r_led[1];
    assign led_b         = r_led[2];

endmodule

`default_nettype wire

// File: tb/tb_pwm_rgb_led_axil_slave.sv
// ============================================================================
//  Module      : tb_pwm_rgb_led_axil_slave
//  Description : Self-checking bench for the AXI4-Lite RGB PWM slave, with a
//                cycle-level reference model of registers and LED outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_rgb_led_axil_slave;

    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        led_r, led_g, led_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_rgb_led_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .PRESCALE           (PRESCALE)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .led_r         (led_r),
        .led_g         (led_g),
        .led_b         (led_b)
    );

    // ------------------------------------------------------------------------
    // Reference model: register contents, cycles since enable, expected LEDs
    // ------------------------------------------------------------------------
    logic [31:0] m_regs [4];
    int          m_t;
    logic [2:0]  m_led;
    int          m_wseq = 0;      // bumped by the driver when a write is accepted
    int          m_wdone;         // model catches up on the commit edge
    int          m_wa = 0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_ws = '0;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] d,
                                          input logic [3:0]  s);
        merge = old_v;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) merge[8*k +: 8] = d[8*k +: 8];
        end
    endfunction

    // Step count is simply elapsed enabled cycles divided by PRESCALE, mod 256
    function automatic logic duty_on(input int t, input logic [31:0] duty);
        return ((t / PRESCALE) % 256) < int'(duty[7:0]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] <= '0;
            m_t     <= 0;
            m_led   <= '0;
            m_wdone <= m_wseq;
        end else begin
            m_led[0] <= m_regs[0][0] && duty_on(m_t, m_regs[1]);
            m_led[1] <= m_regs[0][0] && duty_on(m_t, m_regs[2]);
            m_led[2] <= m_regs[0][0] && duty_on(m_t, m_regs[3]);
            m_t      <= m_regs[0][0] ? m_t + 1 : 0;
            if (m_wseq != m_wdone) begin
                m_regs[m_wa] <= merge(m_regs[m_wa], m_wd, m_ws);
                m_wdone      <= m_wseq;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Record the currently presented write in the model (called the cycle the
    // ready pulse is visible, so it commits on the following edge).
    task automatic note_write();
        m_wa = int'(awaddr[3:2]);
        m_wd = wdata;
        m_ws = wstrb;
        m_wseq++;
    endtask

    task automatic wait_wready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(awready && wready) && n < 50);
        if (awready && wready) note_write();
        else chk("wready_timeout", {awready, wready}, 2'b11);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int bhold);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        wait_wready(n);
        chk("wr_latency", n, 2);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid_rise", bvalid, 1'b1);
        chk("aw_pulse_len", awready, 1'b0);
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1'b1);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        chk("bvalid_fall", bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, input int rhold);
        int n;
        logic [31:0] exp;
        exp = '0;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 50);
        chk("rd_latency", n, 2);
        exp = m_regs[a[3:2]];
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_rise", rvalid, 1'b1);
        chk("rdata", rdata, exp);
        chk("ar_pulse_len", arready, 1'b0);
        for (int i = 0; i < rhold; i++) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, exp);
        end
        d = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk("rvalid_fall", rvalid, 1'b0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [31:0] d;
        int n;
        int cnt_r, cnt_g, cnt_b;

        // Per-cycle comparison of DUT outputs against the model
        fork
            forever begin
                @(negedge clk);
                chk("leds", {29'd0, led_b, led_g, led_r}, {29'd0, m_led});
                chk("bresp", bresp, 2'b00);
                chk("rresp", rresp, 2'b00);
                chk("aw_w_ready_pair", awready, wready);
            end
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_leds", {led_b, led_g, led_r}, 3'b000);

        // Reset readback
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), d, 0);
            chk("rst_readback", d, 32'h0);
        end

        // Sequential write and readback
        for (int a = 0; a < 4; a++) axi_write(4'(a * 4), 32'(a + 1), 4'hF, 0);
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), d, 0);
            chk("seq_readback", d, 32'(a + 1));
        end

        // Byte strobes
        axi_write(4'h4, 32'hAABBCCDD, 4'b1111, 0);
        axi_write(4'h4, 32'h11223344, 4'b0101, 0);
        axi_read(4'h4, d, 0);
        chk("strobe_merge", d, 32'hAA22CC44);

        // Backpressure on B and R
        axi_write(4'h8, 32'h5A5A00FF, 4'hF, 10);
        axi_read(4'h4, d, 10);
        chk("bp_readback", d, 32'hAA22CC44);

        // Second write held off while BVALID is pending
        @(posedge clk); #1;
        awaddr = 4'hC; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_wready(n);
        chk("wr1_latency", n, 2);
        @(posedge clk); #1;
        wdata = 32'h77;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("blocked_bvalid", bvalid, 1'b1);
            chk("blocked_awready", awready, 1'b0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        wait_wready(n);
        chk("wr2_after_b", n, 2);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("wr2_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(4'hC, d, 0);
        chk("wr2_readback", d, 32'h77);

        // PWM duty measurement over one full period
        axi_write(4'h4, 32'd64, 4'hF, 0);
        axi_write(4'h8, 32'd0, 4'hF, 0);
        axi_write(4'hC, 32'd255, 4'hF, 0);
        axi_write(4'h0, 32'd1, 4'hF, 0);
        cnt_r = 0; cnt_g = 0; cnt_b = 0;
        for (int i = 0; i < 256 * PRESCALE; i++) begin
            @(negedge clk);
            cnt_r += int'(led_r);
            cnt_g += int'(led_g);
            cnt_b += int'(led_b);
        end
        chk("pwm_r_high", cnt_r, 256);
        chk("pwm_g_high", cnt_g, 0);
        chk("pwm_b_high", cnt_b, 1020);

        // Disabling forces LEDs low
        axi_write(4'h0, 32'd0, 4'hF, 0);
        chk("disable_leds", {led_b, led_g, led_r}, 3'b000);

        // Simultaneous read and write of the same register returns old data
        @(posedge clk); #1;
        awaddr = 4'h8; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h8; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("sim_awready", awready, 1'b1);
        chk("sim_arready", arready, 1'b1);
        d = m_regs[2];
        note_write();
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("sim_bvalid", bvalid, 1'b1);
        chk("sim_rvalid", rvalid, 1'b1);
        chk("sim_rdata_model", rdata, d);
        chk("sim_rdata_old", rdata, 32'h0);
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        axi_read(4'h8, d, 0);
        chk("sim_new_value", d, 32'h12345678);

        // Asynchronous reset while read data is pending
        axi_write(4'h0, 32'd1, 4'hF, 0);
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        araddr = 4'hC; arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 50);
        chk("ar_before_reset", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_before_reset", rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rvalid", rvalid, 1'b0);
        chk("async_leds", {led_b, led_g, led_r}, 3'b000);
        chk("async_rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), d, 0);
            chk("post_reset_readback", d, 32'h0);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_rgb_led_axil_slave.md
# pwm_rgb_led_axil_slave

AXI4-Lite responder for the RGB PWM LED peripheral. It decodes writes and reads from the processor or AXI VIP master into four 32-bit registers and drives three PWM outputs from them. It is the slave end of the S00_AXI bus that the peripheral's example bench exercises with sequential single-beat writes and readbacks.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects the register.
- PRESCALE, 4, clock cycles per PWM counter step; legal range ≥1.

- S_AXI_ACLK  in  1  single clock; all logic is rising-edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data.
- led_r, led_g, led_b  out  1 each  PWM outputs, active-high.

## Operation
- Register map, all 32-bit read/write with full readback:
  - 0x0 CTRL: bit0 = enable.
  - 0x4 DUTY_R.
  - 0x8 DUTY_G.
  - 0xC DUTY_B.
  - Only bits [7:0] of each DUTY register drive the PWM. The upper bits are stored and read back unchanged.
- Byte lanes: byte k of the addressed register is updated only when WSTRB[k]=1.
- Address bits [1:0] are ignored. Every address decodes, so there is no SLVERR/DECERR.
- Write path:
  - AWREADY and WREADY are registered. Both pulse high together for exactly one cycle once AWVALID and WVALID are both high, AWREADY is low, and no BVALID is pending.
  - The register is written on that handshake edge.
  - BVALID rises the next cycle and holds until BREADY is sampled high.
  - A new write is not accepted while BVALID=1.
- Read path:
  - ARREADY pulses high for one cycle when ARVALID=1, ARREADY=0 and RVALID=0.
  - On that edge the addressed register is captured into RDATA.
  - RVALID rises the next cycle. RVALID and RDATA hold until RREADY is sampled high.
- Simultaneous read and write: the two paths are independent.
  - A read of the register being written in the same cycle returns the old value.
- PWM:
  - A prescaler counts 0..PRESCALE-1. An 8-bit counter cnt increments when the prescaler wraps, and wraps 255→0.
  - Both counters run only while CTRL[0]=1 and are held at 0 while CTRL[0]=0.
  - Each output is registered: led_x = CTRL[0] & (cnt < DUTY_x[7:0]).
  - DUTY=0 gives a constant 0. DUTY=255 gives high 255 of every 256 steps.
  - A new duty takes effect on the next comparison, with no glitch protection.

## Timing
- Reset values: all registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; RDATA = 0; BRESP = RRESP = 0; led_r/g/b = 0; counters = 0.
- Reset asserted mid-transaction aborts it immediately. Any pending BVALID/RVALID drops, and no register write occurs unless the write handshake edge already completed.
- Write latency: AW/W valid at cycle N gives the ready pulse at N+1 and BVALID at N+2.
  - With BREADY held high, back-to-back writes complete every 3 cycles.
- Read latency: ARVALID at cycle N gives ARREADY at N+1 and RVALID with data at N+2.
- AWVALID without WVALID, or the reverse: no ready is asserted and the block waits indefinitely.
- PWM period is 256×PRESCALE cycles. The output updates 1 cycle after cnt changes.

## Test plan
- Reset readback: release reset, read 0x0/0x4/0x8/0xC → each returns 0x00000000, RRESP=0. All LEDs stay 0.
- Sequential write/readback: write 1,2,3,4 to 0x0,0x4,0x8,0xC → each BRESP=0. Reading back returns 1,2,3,4 in order.
- Byte strobes: write 0xAABBCCDD to 0x4 with WSTRB=4'b1111, then 0x11223344 with WSTRB=4'b0101 → read of 0x4 returns 0xAA22CC44.
- Backpressure: hold BREADY=0 for 10 cycles after a write, and RREADY=0 for 10 cycles after a read.
  - BVALID, RVALID and RDATA must stay stable.
  - A second AWVALID/WVALID pair is not accepted until B completes.
- PWM duty, PRESCALE=4:
  - CTRL=1, DUTY_R=64, DUTY_G=0, DUTY_B=255 → over 1024 cycles led_r is high for 256 cycles, led_g for 0, led_b for 1020.
  - Writing CTRL=0 forces all LEDs to 0 within 1 cycle.
- Async reset mid-read: assert ARESETN=0 while RVALID=1 → RVALID and LEDs drop without waiting for a clock edge. Registers read 0 after release.
